pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

Sequencer for the iCE40 `SB_PLL40_PAD` clock generator. It runs on the PLL's 12 MHz reference clock. It drives the PLL `RESETB` pin, watches `LOCK`, and holds the SoC reset until lock has been stable for a programmable time. On lock loss it re-asserts the system reset and restarts the PLL; on lock timeout it retries. `sys_resetn` is synchronous to `clk`; each consumer clock domain re-synchronizes it.

## Interface
- `PLL_RESET_CYCLES`, 16: cycles `pll_resetb` is held low per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles waited for lock before a retry (≥2).
- Counter width is `$clog2` of the largest of the three, plus 1.

Ports:
- `clk`  in  1  12 MHz reference clock, the PLL input pin clock.
- `resetn`  in  1  asynchronous active-low reset.
- `pll_lock`  in  1  PLL `LOCK`; asynchronous to `clk`.
- `sw_reset_req`  in  1  single-cycle request to restart the PLL and the system.
- `pll_resetb`  out  1  to PLL `RESETB`; 0 holds the PLL in reset.
- `sys_resetn`  out  1  system reset, active-low, registered.
- `ready`  out  1  high only in state RUN.
- `retry_cnt`  out  4  number of lock timeouts; saturates at 15.
- `lock_lost`  out  1  sticky; set when lock drops while in RUN.

## Operation
- `pll_lock` passes through a 2-flop synchronizer. The synchronizer output is `lock_s`.
- States and their outputs:
  - PLL_RST: `pll_resetb`=0, `sys_resetn`=0.
  - WAIT_LOCK: `pll_resetb`=1, `sys_resetn`=0.
  - STABLE: `pll_resetb`=1, `sys_resetn`=0.
  - RUN: `pll_resetb`=1, `sys_resetn`=1.
- PLL_RST: the counter increments every cycle. At count `PLL_RESET_CYCLES-1` → WAIT_LOCK, counter cleared.
- WAIT_LOCK:
  - `lock_s`=1 → STABLE, counter cleared.
  - Otherwise the counter increments. At `LOCK_TIMEOUT_CYCLES-1` → PLL_RST, counter cleared, `retry_cnt`+1 (saturating).
- STABLE:
  - `lock_s`=0 → WAIT_LOCK, counter cleared. The timeout restarts from 0.
  - Otherwise the counter increments. At `LOCK_STABLE_CYCLES-1` → RUN.
- RUN: `lock_s`=0 → PLL_RST, counter cleared, `lock_lost` set.
- `sw_reset_req`=1 has priority over every other transition. It forces → PLL_RST and clears the counter from any state, including PLL_RST itself, which restarts the pulse.
  - It does not change `retry_cnt`.
  - If it coincides with lock loss in RUN, the next state is PLL_RST and `lock_lost` is still set.
- `retry_cnt` and `lock_lost` clear only on `resetn`.
- All outputs are registered. `ready` and `sys_resetn` change on the same edge as the state.

## Timing
- Values during and after `resetn` low:
  - State PLL_RST, counter 0.
  - `pll_resetb`=0, `sys_resetn`=0, `ready`=0, `retry_cnt`=0, `lock_lost`=0.
  - Synchronizer flops 0.
- After `resetn` rises, `pll_resetb` stays low for exactly `PLL_RESET_CYCLES` rising edges.
- Lock to release latency: `pll_lock` rises (setup met) in WAIT_LOCK. `sys_resetn` and `ready` rise on the `LOCK_STABLE_CYCLES+3`-th edge (2 sync + 1 transition + N stable).
- Lock loss latency: `pll_lock` falls in RUN. `sys_resetn`=0, `pll_resetb`=0 and `lock_lost`=1 appear on the 3rd edge.
- `sw_reset_req` latency: outputs reflect PLL_RST on the next edge.
- A lock glitch shorter than 1 cycle may be missed by the synchronizer. No guarantee is given for such glitches.

## Configuration
- `PLL_RETRY_EN` defined: WAIT_LOCK timeout behaviour as described above.
- `PLL_RETRY_EN` undefined:
  - WAIT_LOCK waits indefinitely. No timeout.
  - `retry_cnt` is tied to 0.
  - `LOCK_TIMEOUT_CYCLES` is ignored and excluded from the counter width.

## Test plan
All scenarios use `PLL_RESET_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, with `PLL_RETRY_EN` defined unless stated.
- Reset, then `pll_lock` rises 10 cycles later and stays high:
  - `pll_resetb` low for exactly 4 edges after `resetn` rises.
  - `sys_resetn`=`ready`=1 exactly 11 edges after `pll_lock` rises.
  - `retry_cnt`=0.
- `pll_lock` never rises:
  - `pll_resetb` pulses low for 4 cycles every 36 cycles.
  - `retry_cnt` counts 1, 2, … and stays at 15 after the 15th timeout.
  - `sys_resetn` stays 0 throughout.
- In STABLE, `pll_lock` drops for 3 cycles after 5 stable cycles, then returns:
  - No release at the original time.
  - Release 11 edges after the re-rise.
  - `pll_resetb` stays 1 throughout.
- In RUN, `pll_lock` falls:
  - `sys_resetn`=0, `pll_resetb`=0 and `lock_lost`=1 on the 3rd edge.
  - The full sequence then repeats.
  - `lock_lost` stays 1 after the next release.
- `sw_reset_req` pulsed in RUN, in STABLE and mid-PLL_RST:
  - Next edge is PLL_RST and the 4-cycle pulse restarts.
  - `lock_lost` and `retry_cnt` are unchanged.
- Build without `PLL_RETRY_EN`, `pll_lock` held low for 100 cycles:
  - Single 4-cycle `pll_resetb` pulse only.
  - `retry_cnt`=0.
  - Lock at cycle 100 releases 11 edges later.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// iCE40 SB_PLL40_PAD reset/lock sequencer, runs on the 12 MHz ref clock.
// Optional feature macro: PLL_RETRY_EN (lock-timeout retry + retry_cnt).
module pll_reset_ctrl #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       sw_reset_req,
  output logic       pll_resetb,
  output logic       sys_resetn,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  localparam int MAX_A = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                         PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
`ifdef PLL_RETRY_EN
  localparam int MAX_C = (MAX_A > LOCK_TIMEOUT_CYCLES) ?
                         MAX_A : LOCK_TIMEOUT_CYCLES;
`else
  localparam int MAX_C = MAX_A;
`endif
  localparam int CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] C_RST_END = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] C_STB_END = CW'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_RETRY_EN
  localparam logic [CW-1:0] C_TO_END  = CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_sync1;
  logic            r_lock_s;
  logic            r_pll_resetb;
  logic            r_sys_resetn;
  logic            r_ready;
  logic            r_lock_lost;
  logic            w_lost_set;
`ifdef PLL_RETRY_EN
  logic            w_timeout;
  logic [3:0]      r_retry;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_lost_set = 1'b0;
`ifdef PLL_RETRY_EN
    w_timeout  = 1'b0;
`endif
    unique case (r_state)
      S_PLL_RST: begin
        if (r_cnt == C_RST_END) begin
          w_next    = S_WAIT_LOCK;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_next    = S_STABLE;
          w_cnt_nxt = '0;
        end
`ifdef PLL_RETRY_EN
        else if (r_cnt == C_TO_END) begin
          w_next    = S_PLL_RST;
          w_cnt_nxt = '0;
          w_timeout = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      S_STABLE: begin
        if (!r_lock_s) begin
          w_next    = S_WAIT_LOCK;
          w_cnt_nxt = '0;
        end else if (r_cnt == C_STB_END) begin
          w_next    = S_RUN;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_next     = S_PLL_RST;
          w_cnt_nxt  = '0;
          w_lost_set = 1'b1;
        end
      end
      default: begin
        w_next    = S_PLL_RST;
        w_cnt_nxt = '0;
      end
    endcase
    // Software restart wins, but a coincident lock loss is still recorded
    if (sw_reset_req) begin
      w_next    = S_PLL_RST;
      w_cnt_nxt = '0;
`ifdef PLL_RETRY_EN
      w_timeout = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_pll_resetb <= 1'b0;
      r_sys_resetn <= 1'b0;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_nxt;
      r_pll_resetb <= (w_next != S_PLL_RST);
      r_sys_resetn <= (w_next == S_RUN);
      r_ready      <= (w_next == S_RUN);
      if (w_lost_set) begin
        r_lock_lost <= 1'b1;
      end
    end
  end

`ifdef PLL_RETRY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_retry <= 4'd0;
    end else if (w_timeout && (r_retry != 4'hF)) begin
      r_retry <= r_retry + 4'd1;
    end
  end

  assign retry_cnt = r_retry;
`else
  assign retry_cnt = 4'd0;
`endif

  assign pll_resetb = r_pll_resetb;
  assign sys_resetn = r_sys_resetn;
  assign ready      = r_ready;
  assign lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed scenarios plus random lock/sw traffic
// checked against a timestamp-based reference model.
module tb_pll_reset_ctrl;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTO = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_resetb;
  logic       sys_resetn;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  int checks = 0;
  int failures = 0;

  // Reference model: edge index plus timestamps of the last events
  int t = 0;
  int rst_at = 0;
  int wait_at = 0;
  int good_from = -1;
  bit pulsing = 1'b1;
  bit run = 1'b0;
  bit m_lost = 1'b0;
  int m_retry = 0;
  bit s1 = 1'b0;
  bit s2 = 1'b0;

  bit pr_low_seen = 1'b0;
  bit sys_hi_seen = 1'b0;

  pll_reset_ctrl #(
    .PLL_RESET_CYCLES   (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pll_lock    (pll_lock),
    .sw_reset_req(sw_reset_req),
    .pll_resetb  (pll_resetb),
    .sys_resetn  (sys_resetn),
    .ready       (ready),
    .retry_cnt   (retry_cnt),
    .lock_lost   (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic restart();
    rst_at    = t;
    pulsing   = 1'b1;
    run       = 1'b0;
    good_from = -1;
  endtask

  task automatic model_step();
    bit ls;
    ls = s2;
    s2 = s1;
    s1 = pll_lock;
    t++;
    if (sw_reset_req) begin
      if (run && !ls) m_lost = 1'b1;
      restart();
    end else if (run) begin
      if (!ls) begin
        m_lost = 1'b1;
        restart();
      end
    end else if (pulsing) begin
      if (t - rst_at == PRC) begin
        pulsing = 1'b0;
        wait_at = t;
      end
    end else if (good_from < 0) begin
      if (ls) good_from = t;
`ifdef PLL_RETRY_EN
      else if (t - wait_at == LTO) begin
        if (m_retry < 15) m_retry++;
        restart();
      end
`endif
    end else if (!ls) begin
      good_from = -1;
      wait_at   = t;
    end else if (t - good_from == LSC) begin
      run = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("pll_resetb", 32'(pll_resetb), 32'(!pulsing));
    chk("sys_resetn", 32'(sys_resetn), 32'(run));
    chk("ready", 32'(ready), 32'(run));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    if (pll_resetb === 1'b0) pr_low_seen = 1'b1;
    if (sys_resetn === 1'b1) sys_hi_seen = 1'b1;
  endtask

  task automatic wait_sys(input logic v, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      tick();
      if (sys_resetn === v) at = t;
    end
  endtask

  task automatic wait_pr_hi(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      tick();
      if (pll_resetb === 1'b1) at = t;
    end
  endtask

  task automatic sw_pulse();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
  endtask

  initial begin
    int at;
    int mark;
    int cnt;
    int prev_fall;
    logic prev_pr;
    logic sv_lost;
    logic [3:0] sv_retry;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pll_resetb", 32'(pll_resetb), 0);
    chk("rst_sys_resetn", 32'(sys_resetn), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Power-up: lock rises 10 cycles after reset release
    wait_pr_hi(10, at);
    chk("pulse_len", at, PRC);
    repeat (10 - at) tick();
    pll_lock = 1'b1;
    mark = t;
    wait_sys(1'b1, 40, at);
    chk("release_lat", at - mark, LSC + 3);
    chk("release_retry", 32'(retry_cnt), 0);

    // Lock drop inside STABLE delays release
    pll_lock = 1'b0;
    sw_pulse();
    repeat (6) tick();
    pll_lock = 1'b1;
    mark = t;
    pr_low_seen = 1'b0;
    sys_hi_seen = 1'b0;
    repeat (7) tick();
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    chk("no_early_release", 32'(sys_hi_seen), 0);
    mark = t;
    wait_sys(1'b1, 40, at);
    chk("rerise_release_lat", at - mark, LSC + 3);
    chk("stable_pr_high", 32'(pr_low_seen), 0);

    // Lock loss in RUN
    pll_lock = 1'b0;
    mark = t;
    wait_sys(1'b0, 10, at);
    chk("loss_lat", at - mark, 3);
    chk("loss_pll_resetb", 32'(pll_resetb), 0);
    chk("loss_lock_lost", 32'(lock_lost), 1);
    pll_lock = 1'b1;
    wait_sys(1'b1, 40, at);
    chk("relock_lat", at - mark, 3 + PRC + 1 + LSC);
    chk("lost_sticky", 32'(lock_lost), 1);

    // Software restart in RUN, STABLE and mid-pulse
    sv_lost  = lock_lost;
    sv_retry = retry_cnt;
    sw_pulse();
    mark = t;
    chk("sw_run_pr", 32'(pll_resetb), 0);
    chk("sw_run_sys", 32'(sys_resetn), 0);
    wait_pr_hi(10, at);
    chk("sw_run_pulse", at - mark, PRC);
    repeat (3) tick();
    sw_pulse();
    mark = t;
    chk("sw_stable_pr", 32'(pll_resetb), 0);
    repeat (2) tick();
    sw_pulse();
    mark = t;
    wait_pr_hi(10, at);
    chk("sw_mid_pulse", at - mark, PRC);
    chk("sw_lost_kept", 32'(lock_lost), 32'(sv_lost));
    chk("sw_retry_kept", 32'(retry_cnt), 32'(sv_retry));
    wait_sys(1'b1, 40, at);
    chk("sw_release", 32'(at > 0), 1);

    // Random lock toggles and software restarts
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
      sw_reset_req = ($urandom_range(0, 99) == 0);
      tick();
    end
    sw_reset_req = 1'b0;

`ifdef PLL_RETRY_EN
    // Lock never comes: periodic pulses, saturating retry count
    pll_lock = 1'b0;
    repeat (3) tick();
    sw_pulse();
    sys_hi_seen = 1'b0;
    prev_fall = -1;
    prev_pr = pll_resetb;
    cnt = 0;
    for (int i = 0; i < 17 * (LTO + PRC); i++) begin
      tick();
      if (prev_pr === 1'b1 && pll_resetb === 1'b0) begin
        if (prev_fall >= 0) chk("retry_period", t - prev_fall, LTO + PRC);
        prev_fall = t;
        cnt++;
      end
      prev_pr = pll_resetb;
    end
    chk("retry_pulses", cnt, 17);
    chk("retry_sat", 32'(retry_cnt), 15);
    chk("retry_sys_low", 32'(sys_hi_seen), 0);
`else
    // No retry: single pulse, then indefinite wait
    pll_lock = 1'b0;
    repeat (3) tick();
    sw_pulse();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pll_resetb === 1'b0) cnt++;
    end
    chk("noretry_low_cnt", cnt, PRC - 1);
    chk("noretry_retry", 32'(retry_cnt), 0);
    pll_lock = 1'b1;
    mark = t;
    wait_sys(1'b1, 40, at);
    chk("noretry_release", at - mark, LSC + 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
